// File: rtl/stream_mux_rr_if.sv
// Stream bundle between NCH producers, the round-robin mux and one consumer.
// The master modport is the producer/consumer side; slave is the mux itself.
interface stream_mux_rr_if #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = 2
);
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_last;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_last;
  logic [SELW-1:0]      out_sel;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_last, out_sel, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_last, out_sel, out_valid
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel packet-aware stream mux: round-robin or fixed-priority arbitration,
// grant held until last, selected beat registered into a one-entry output stage.
module stream_mux_rr #(
  parameter int WIDTH     = 4,
  parameter int NCH       = 4,
  parameter int SELW      = 2,
  parameter int PRIO_MODE = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  stream_mux_rr_if.slave  bus
);

  typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_e;

  lock_state_e      state_q, state_d;
  logic [SELW-1:0]  lock_ch_q, lock_ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;
  logic [SELW-1:0]  out_sel_q;

  logic [WIDTH-1:0] ch_data [NCH];
  logic [NCH-1:0]   elig;
  logic             gnt_vld;
  logic [SELW-1:0]  gnt_idx;
  logic [SELW-1:0]  cand;
  int               idx;
  logic             ld;
  logic             accept;

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign ch_data[g] = bus.in_data[g*WIDTH +: WIDTH];
  end

  // State register: lock FSM, pointer and the output stage.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_OPEN;
      lock_ch_q   <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      ptr_q     <= ptr_d;
      if (ld) begin
        out_valid_q <= gnt_vld;
        if (gnt_vld) begin
          out_data_q <= ch_data[gnt_idx];
          out_last_q <= bus.in_last[gnt_idx];
          out_sel_q  <= gnt_idx;
        end
      end
    end
  end

  // Arbitration and outputs. The search starts at ptr in round-robin mode and
  // at channel 0 in fixed-priority mode; the index wraps at NCH, not 2^SELW.
  // NOTE: every combinationally assigned signal gets a default at the top of
  // the block so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    elig    = bus.in_valid;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    cand    = '0;
    if (state_q == ST_LOCKED) elig = bus.in_valid & (NCH'(1) << lock_ch_q);
    for (int i = 0; i < NCH; i++) begin
      idx = (PRIO_MODE == 0) ? int'(ptr_q) + i : i;
      if (idx >= NCH) idx = idx - NCH;
      cand = SELW'(idx);
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    ld            = !out_valid_q || bus.out_ready;
    accept        = ld && gnt_vld && reset_n;
    bus.in_ready  = accept ? (NCH'(1) << gnt_idx) : '0;
    bus.out_valid = out_valid_q;
    bus.out_data  = out_data_q;
    bus.out_last  = out_last_q;
    bus.out_sel   = out_sel_q;
  end

  // Next state: a non-last beat locks onto its channel; a last beat releases
  // the lock and, in round-robin mode, moves the pointer past the winner.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    ptr_d     = ptr_q;
    if (accept) begin
      if (bus.in_last[gnt_idx]) begin
        state_d = ST_OPEN;
        if (PRIO_MODE == 0) begin
          ptr_d = (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + SELW'(1);
        end
      end else begin
        state_d   = ST_LOCKED;
        lock_ch_d = gnt_idx;
      end
    end
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel streaming multiplexer, the successor to our fixed two-input combinational data mux. It selects among NCH valid/ready input channels with round-robin or fixed-priority arbitration and holds grants for the whole packet (until `last`). It registers the selected beat into a one-entry output stage. It sits between multiple producers (e.g. datapath result sources) and a single downstream consumer.

## Interface
- WIDTH, 4, data bits per channel
- NCH, 4, number of input channels (≥1)
- SELW, 2, width of channel index; 2^SELW ≥ NCH required
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (channel 0 highest)

- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_data  input  NCH*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- in_valid  input  NCH  per-channel beat valid
- in_last  input  NCH  per-channel end-of-packet flag
- in_ready  output  NCH  per-channel accept (combinational)
- out_data  output  WIDTH  registered selected beat
- out_last  output  1  registered last flag
- out_sel  output  SELW  index of channel that supplied the held beat
- out_valid  output  1  output register holds a beat
- out_ready  input  1  consumer accepts beat

## Operation
- Beat transfer: input i transfers when in_valid[i] && in_ready[i]; output transfers when out_valid && out_ready.
- Load enable `ld = !out_valid || out_ready`. At most one in_ready bit is high. It is high only for granted channel g and only when ld=1 and reset_n=1.
- Eligible set: if `lock`=1, only `lock_ch` is eligible. Otherwise all channels with in_valid=1 are eligible.
- Grant, round-robin: the first eligible channel searching ptr, ptr+1, …, NCH-1, 0, …, ptr-1.
- Grant, fixed priority: the lowest-index eligible channel.
- On ld with a grant: capture in_data[g], in_last[g], and g into the output register; out_valid←1.
- On ld with no grant: out_valid←0. Data, last and sel hold their previous values.
- Lock: accepting a beat with last=0 sets lock←1, lock_ch←g. Accepting a beat from lock_ch with last=1 sets lock←0.
  - While locked, valid beats on other channels are ignored (their in_ready stays 0).
  - If lock_ch drops in_valid, no beat is issued; the lock holds.
- Pointer: ptr←(g+1) mod NCH on acceptance of a last=1 beat (round-robin mode only). Rotation is therefore per packet, not per beat.
- Single-beat packet (last=1, not locked): grant, no lock, ptr advances.
- NCH=1: always grants channel 0; ptr stays 0.
- Width rule: the ptr increment wraps at NCH, not at 2^SELW.

## Timing
- Latency: an input beat accepted at edge k appears on out_* after edge k (valid in cycle k+1).
- Throughput: 1 beat/cycle with out_ready held high. There are no bubbles, including across packet boundaries and channel switches.
- Backpressure: with out_valid=1 and out_ready=0, all in_ready are 0 and out_* are stable.
- Simultaneous output drain and new capture in the same cycle is allowed; it is the normal pipelined case.
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, out_data=0, out_last=0, out_sel=0, ptr=0, lock=0, lock_ch=0.
  - in_ready=0 while reset_n=0.
- Reset mid-packet discards the held beat and the lock. After release, arbitration restarts from channel 0.

## Test plan
- Single channel: NCH=4, ch2 sends beats 0x5, 0xA (last on 0xA), out_ready=1 → out_data 0x5 then 0xA one cycle after each acceptance, out_sel=2, out_last on second, ptr=3 afterwards.
- Round-robin fairness: all 4 channels continuously valid with single-beat packets, out_ready=1 → out_sel sequence 0,1,2,3,0,… with out_valid continuously 1.
- Packet lock: ch1 sends a 3-beat packet while ch0 and ch3 are valid → three consecutive ch1 beats, then the next grant is ch3 (ptr=2 search: 2 empty, 3). ch1 dropping valid mid-packet → out_valid=0 and no other grant.
- Backpressure: out_ready=0 for 5 cycles with beat 0x7 held → out_data stays 0x7, all in_ready=0; on release, next beat follows in the next cycle with no loss or duplicate.
- Fixed priority (PRIO_MODE=1): ch0 and ch3 both continuously valid with single-beat packets → out_sel stays 0. ch3 is granted only when ch0 deasserts.
- Reset mid-packet: assert reset_n=0 during a locked ch2 packet → out_valid=0 and in_ready=0 immediately. After release, with ch0 and ch2 valid, the first grant goes to ch0.
